hit_controller_multi: RTL
=========================

HIT_CONTROLLER_MULTI -- requirements
Module: hit_controller_multi

Interface
REQ-001 The block SHALL have parameter NUM_LASERS, default 4, giving the number of independent user-laser channels (1..8).
REQ-002 The block SHALL have parameter SHIP_SIZE, default 30, giving the enemy ship box edge in pixels.
REQ-003 The block SHALL have parameters LASER_X_SIZE and LASER_Y_SIZE, defaults 20 and 49, giving the laser box width and height in pixels.
REQ-004 The block SHALL have parameter BOSS_HP, default 5, giving the boss hit points (1..15).
REQ-005 The block SHALL have parameter COOLDOWN_FRAMES, default 8, giving the invulnerability length in frame ticks (1..255).
REQ-006 The block SHALL have port Clk, input, 1 bit: the single system clock.
REQ-007 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have ports enemy_ship_X_Pos and enemy_ship_Y_Pos, each input, 10 bits: boss top-left corner.
REQ-009 The block SHALL have ports user_laser_x_pos and user_laser_y_pos, each input, NUM_LASERS*10 bits: packed laser top-left corners, with channel i at bits [10i+9:10i].
REQ-010 The block SHALL have port laser_valid, input, NUM_LASERS bits: channel i is in flight.
REQ-011 The block SHALL have port boss_fight, input, 1 bit: the boss round is active.
REQ-012 The block SHALL have port frame_tick, input, 1 bit: a one-cycle pulse issued once per video frame.
REQ-013 The block SHALL have port done, input, 1 bit: a round-end acknowledge that clears the defeated state.
REQ-014 The block SHALL have port laser_hit, output, NUM_LASERS bits: a registered one-cycle pulse per channel meaning the laser was consumed.
REQ-015 The block SHALL have port boss_damaged, output, 1 bit: a registered one-cycle pulse meaning one hit point was removed.
REQ-016 The block SHALL have port boss_hp, output, 4 bits: the remaining hit points.
REQ-017 The block SHALL have port enemy_hit, output, 1 bit: the boss is defeated; the signal is sticky.

Function
REQ-018 Overlap SHALL be computed per channel i as laser_valid[i] AND lx <= ex+SHIP_SIZE AND lx+LASER_X_SIZE >= ex AND ly <= ey+SHIP_SIZE AND ly+LASER_Y_SIZE >= ey.
REQ-019 All overlap sums SHALL be evaluated at 11 bits, so that x=1023 plus a size does not wrap.
REQ-020 The FSM SHALL have exactly the states IDLE, ACTIVE, COOLDOWN and DEFEATED.
REQ-021 IDLE SHALL move to ACTIVE on the first cycle with boss_fight=1, loading boss_hp<=BOSS_HP.
REQ-022 In ACTIVE or COOLDOWN, laser_hit[i] SHALL pulse one cycle after every cycle in which channel i overlaps.
REQ-023 In ACTIVE, any overlap SHALL decrement boss_hp by exactly 1, regardless of how many channels overlap, and SHALL pulse boss_damaged.
REQ-024 After such a decrement, the FSM SHALL enter COOLDOWN if the new boss_hp > 0, or DEFEATED if it equals 0.
REQ-025 COOLDOWN SHALL load the frame counter with COOLDOWN_FRAMES and decrement it on each frame_tick.
REQ-026 COOLDOWN SHALL return to ACTIVE on the frame_tick that takes the counter to 0.
REQ-027 In COOLDOWN, overlapping lasers SHALL be consumed via laser_hit but SHALL cause no damage.
REQ-028 In DEFEATED, enemy_hit SHALL be 1, laser_hit SHALL be all 0, and boss_hp SHALL be 0.
REQ-029 DEFEATED SHALL go to IDLE on done=1.
REQ-030 When boss_fight=0 in any state, the FSM SHALL go to IDLE next cycle, with all pulses 0 and enemy_hit=0.
REQ-031 When done=1 and an overlap occur in the same cycle in DEFEATED, done SHALL win.
REQ-032 When boss_fight falls in the same cycle as an overlap, no damage SHALL be applied.
REQ-033 boss_hp SHALL never underflow below 0 and SHALL never reload mid-fight.
REQ-034 In IDLE, all outputs SHALL be 0 and boss_hp SHALL hold its last value.

Reset
REQ-035 Reset=0 SHALL asynchronously force state IDLE, boss_hp=0, frame counter=0, laser_hit=0, boss_damaged=0 and enemy_hit=0.
REQ-036 A Reset asserted mid-COOLDOWN or mid-DEFEATED SHALL abandon the fight; after release, a fresh IDLE->ACTIVE entry SHALL reload BOSS_HP.

Verification
REQ-037 The bench SHALL check: boss (100,100) with laser0 at (110,120) valid in ACTIVE -> next cycle laser_hit=0001, boss_damaged=1, boss_hp 5->4, state COOLDOWN.
REQ-038 The bench SHALL check: lasers 0 and 2 overlapping in the same ACTIVE cycle -> laser_hit=0101 and boss_hp decremented by exactly 1.
REQ-039 The bench SHALL check: an overlap during COOLDOWN -> laser_hit pulses and boss_hp is unchanged; ACTIVE resumes exactly on the 8th frame_tick.
REQ-040 The bench SHALL check: five spaced hits -> boss_hp=0 and enemy_hit=1 held; done=1 -> IDLE and enemy_hit=0 next cycle.
REQ-041 The bench SHALL check: a laser at x=1015 with boss at x=1000 -> overlap detected with no wrap, and a laser at x=960 -> no overlap.
REQ-042 The bench SHALL check: Reset pulsed low mid-COOLDOWN -> all outputs 0 immediately; re-entry loads boss_hp=5.

Source files
------------

// File: rtl/hit_controller_multi.sv
`default_nettype none
// ============================================================================
// Module      : hit_controller_multi
// Description : Boss-fight hit controller. Up to NUM_LASERS user lasers are
//               tested against the boss box each cycle. Overlapping lasers
//               are consumed. A hit removes one boss hit point and then
//               opens a frame-counted invulnerability window.
// Revision    : 1.0 - initial release
// ============================================================================
module hit_controller_multi #(
    parameter int NUM_LASERS      = 4,
    parameter int SHIP_SIZE       = 30,
    parameter int LASER_X_SIZE    = 20,
    parameter int LASER_Y_SIZE    = 49,
    parameter int BOSS_HP         = 5,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [9:0]               enemy_ship_X_Pos,
    input  logic [9:0]               enemy_ship_Y_Pos,
    input  logic [NUM_LASERS*10-1:0] user_laser_x_pos,
    input  logic [NUM_LASERS*10-1:0] user_laser_y_pos,
    input  logic [NUM_LASERS-1:0]    laser_valid,
    input  logic                     boss_fight,
    input  logic                     frame_tick,
    input  logic                     done,
    output logic [NUM_LASERS-1:0]    laser_hit,
    output logic                     boss_damaged,
    output logic [3:0]               boss_hp,
    output logic                     enemy_hit
);

    // The comparisons run at 11 bits so a coordinate near 1023 plus a box
    // size cannot wrap around and produce a false miss.
    localparam logic [10:0] c_ship_size = 11'(SHIP_SIZE);
    localparam logic [10:0] c_laser_x   = 11'(LASER_X_SIZE);
    localparam logic [10:0] c_laser_y   = 11'(LASER_Y_SIZE);
    localparam logic [3:0]  c_boss_hp   = 4'(BOSS_HP);
    localparam logic [7:0]  c_cooldown  = 8'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        COOLDOWN  = 2'd2,
        DEFEATED  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             boss_hp_q, boss_hp_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;
    logic [NUM_LASERS-1:0]  laser_hit_q, laser_hit_d;
    logic                   boss_damaged_q, boss_damaged_d;

    logic [10:0]            w_ex;
    logic [10:0]            w_ey;
    logic [NUM_LASERS-1:0]  w_overlap;

    assign w_ex = {1'b0, enemy_ship_X_Pos};
    assign w_ey = {1'b0, enemy_ship_Y_Pos};

    generate
        for (genvar i = 0; i < NUM_LASERS; i++) begin : g_overlap
            logic [10:0] w_lx;
            logic [10:0] w_ly;
            assign w_lx = {1'b0, user_laser_x_pos[10*i +: 10]};
            assign w_ly = {1'b0, user_laser_y_pos[10*i +: 10]};
            assign w_overlap[i] = laser_valid[i]
                               && (w_lx <= w_ex + c_ship_size)
                               && (w_lx + c_laser_x >= w_ex)
                               && (w_ly <= w_ey + c_ship_size)
                               && (w_ly + c_laser_y >= w_ey);
        end
    endgenerate

    // Next-state and next-output decode; dropping boss_fight overrides all.
    always_comb begin
        state_d        = state_q;
        boss_hp_d      = boss_hp_q;
        frame_cnt_d    = frame_cnt_q;
        laser_hit_d    = '0;
        boss_damaged_d = 1'b0;
        if (!boss_fight) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ACTIVE;
                    boss_hp_d = c_boss_hp;
                end
                ACTIVE: begin
                    laser_hit_d = w_overlap;
                    // Any number of simultaneous hits costs only one point.
                    if ((|w_overlap) && (boss_hp_q != 4'd0)) begin
                        boss_hp_d      = boss_hp_q - 4'd1;
                        boss_damaged_d = 1'b1;
                        if (boss_hp_q == 4'd1) begin
                            state_d = DEFEATED;
                        end else begin
                            state_d     = COOLDOWN;
                            frame_cnt_d = c_cooldown;
                        end
                    end
                end
                COOLDOWN: begin
                    laser_hit_d = w_overlap;
                    if (frame_tick) begin
                        if (frame_cnt_q <= 8'd1) begin
                            frame_cnt_d = 8'd0;
                            state_d     = ACTIVE;
                        end else begin
                            frame_cnt_d = frame_cnt_q - 8'd1;
                        end
                    end
                end
                DEFEATED: begin
                    if (done) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, hit-point, frame counter and pulse registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q        <= IDLE;
            boss_hp_q      <= 4'd0;
            frame_cnt_q    <= 8'd0;
            laser_hit_q    <= '0;
            boss_damaged_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            boss_hp_q      <= boss_hp_d;
            frame_cnt_q    <= frame_cnt_d;
            laser_hit_q    <= laser_hit_d;
            boss_damaged_q <= boss_damaged_d;
        end
    end

    assign laser_hit    = laser_hit_q;
    assign boss_damaged = boss_damaged_q;
    assign boss_hp      = boss_hp_q;
    assign enemy_hit    = (state_q == DEFEATED);

endmodule
`default_nettype wire
